// File: rtl/fetch_queue_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Provides the INITIAL_PC macro default, the NOP encoding, the queue entry
// layout and the PC alignment helper.

`ifndef INITIAL_PC
`define INITIAL_PC 32'h0000_0000
`endif

package fetch_queue_unit_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential fetch stride in bytes
    localparam logic [31:0] PC_STEP = 32'd4;

    // One prefetch queue entry: instruction together with its PC
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Word-align an address by clearing the two low bits
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO holding {pc, instr} prefetch entries.
// The head entry is visible combinationally so a pushed response reaches
// the consumer one cycle after it is written. Push while full is accepted
// only together with a pop.

module fetch_fifo
    import fetch_queue_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]  count_reg, count_next;
    logic           do_push;
    logic           do_pop;
    logic [DEPTH-1:0] wr_en;
    fetch_entry_t   mem_reg [DEPTH];

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign count = count_reg;
    assign dout  = mem_reg[rd_ptr_reg];

    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    // One write strobe per storage slot
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Pointer and occupancy update; flush empties the queue in one cycle
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry storage; contents need no reset because the head is masked when empty
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) mem_reg[i] <= din;
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: request/response engine with a bounded number
// of in-flight memory requests feeding a prefetch queue towards IF/ID.
// Stale responses after a redirect are counted out and dropped.
// Optional macro FETCH_BYPASS_EN lets a response reach the IF outputs in the
// same cycle when the queue is empty. Macro INITIAL_PC sets the default
// reset fetch address.

module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] INITIAL_PC      = `INITIAL_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;   // queue count width
    localparam int OW = $clog2(MAX_OUTSTANDING + 1); // in-flight counter width
    localparam int SW = CW + 1;                    // count + outstanding width

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   resp_pc_reg, resp_pc_next;
    logic [OW-1:0] outstanding_reg, outstanding_next;
    logic [OW-1:0] discard_reg, discard_next;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_din;

    logic [SW-1:0] occupancy;
    logic          grant;
    logic          rsp_keep;
    logic          bypass_hit;
    logic          queue_room;

    // Slots already claimed: entries held plus responses still to come
    assign occupancy = {1'b0, fifo_count} + SW'(outstanding_reg);

    // Only request when a queue slot is guaranteed for the eventual response
    assign imem_req  = !reset && !redirect
                       && (outstanding_reg < OW'(MAX_OUTSTANDING))
                       && (occupancy < SW'(QUEUE_DEPTH));
    assign imem_addr = fetch_pc_reg;
    assign grant     = imem_req && imem_gnt;

    // A response is kept only if it belongs to the current fetch stream
    assign rsp_keep  = imem_rvalid && !reset && !redirect && (discard_reg == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = rsp_keep && fifo_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    // Request gating already reserves the slot; this only protects the entry
    assign queue_room = !fifo_full || fifo_pop;
    assign fifo_push  = rsp_keep && queue_room && !(bypass_hit && id_ready);
    assign fifo_pop   = !fifo_empty && id_ready && !redirect;
    assign fifo_din   = '{pc: resp_pc_reg, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect),
        .din   (fifo_din),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // IF outputs come from the queue head, or straight from memory on bypass
    always_comb begin
        if_valid = !fifo_empty;
        if_pc    = fifo_empty ? 32'h0 : fifo_head.pc;
        if_instr = fifo_empty ? 32'h0 : fifo_head.instr;
        if (bypass_hit) begin
            if_valid = 1'b1;
            if_pc    = resp_pc_reg;
            if_instr = imem_rdata;
        end
    end

    // Fetch/response PCs and in-flight bookkeeping
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        discard_next     = discard_reg;
        outstanding_next = outstanding_reg;

        case ({grant, imem_rvalid})
            2'b10:   outstanding_next = outstanding_reg + OW'(1);
            2'b01:   outstanding_next = outstanding_reg - OW'(1);
            default: outstanding_next = outstanding_reg;
        endcase

        if (redirect) begin
            // Every response still in flight (bar one arriving now) is stale
            fetch_pc_next = align_pc(redirect_pc);
            resp_pc_next  = align_pc(redirect_pc);
            discard_next  = outstanding_reg - OW'(imem_rvalid);
        end else begin
            if (grant) fetch_pc_next = fetch_pc_reg + PC_STEP;
            if (imem_rvalid) begin
                if (discard_reg != '0) discard_next = discard_reg - OW'(1);
                else                   resp_pc_next = resp_pc_reg + PC_STEP;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_reg    <= INITIAL_PC;
            resp_pc_reg     <= INITIAL_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised self-checking bench for fetch_queue_unit. A behavioural memory
// returns in-order responses with variable latency; the reference model is
// simply "the consumed stream is target, target+4, ... since the last
// redirect, each carrying the memory word of its PC".

module tb_fetch_queue_unit;
    import fetch_queue_unit_pkg::*;

    localparam int QD = 4;
    localparam int MO = 2;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_VALID = 1;
`else
    localparam int FIRST_VALID = 2;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    fetch_queue_unit #(
        .QUEUE_DEPTH     (QD),
        .MAX_OUTSTANDING (MO),
        .INITIAL_PC      (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } mem_rsp_t;

    mem_rsp_t    mem_q[$];
    logic [31:0] pc_log[$];
    int          checks_count = 0;
    int          errors_count = 0;
    int          cycle = 0;
    int          last_ready = 0;
    int          inflight = 0;
    int          grants = 0;
    int          consumed = 0;
    int          gnt_pct = 100;
    int          ready_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] last_pc = 32'h0;
    logic        obs_valid;
    logic        obs_req;
    logic [31:0] obs_addr;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_count++;
        if (observed !== expected) begin
            errors_count++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Instruction memory contents as a function of address
    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ NOP_INSTR;
    endfunction

    // One clock cycle: drive inputs at negedge, observe, score, advance
    task automatic step(input logic do_redirect, input logic [31:0] target);
        mem_rsp_t r;
        int lat;
        redirect    = do_redirect;
        redirect_pc = target;
        imem_rvalid = (mem_q.size() > 0) && (mem_q[0].ready <= cycle);
        imem_rdata  = imem_rvalid ? mem_data(mem_q[0].addr) : 32'h0;
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        id_ready    = ($urandom_range(99) < ready_pct);
        #1;
        obs_valid = if_valid;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        if (imem_rvalid) begin
            void'(mem_q.pop_front());
            inflight--;
        end
        if (imem_req && imem_gnt) begin
            check_value("inflight_limit", 32'(inflight < MO), 32'd1);
            lat    = int'($urandom_range(lat_max, lat_min));
            r.addr = imem_addr;
            r.ready = cycle + lat;
            if (r.ready < last_ready) r.ready = last_ready;
            last_ready = r.ready;
            mem_q.push_back(r);
            inflight++;
            grants++;
        end
        if (!do_redirect && if_valid && id_ready) begin
            check_value("if_pc", if_pc, exp_pc);
            check_value("if_instr", if_instr, mem_data(exp_pc));
            $display("xfer cyc=%0d pc=%h instr=%h", cycle, if_pc, if_instr);
            last_pc = if_pc;
            pc_log.push_back(if_pc);
            exp_pc  = exp_pc + 32'd4;
            consumed++;
        end
        if (do_redirect) exp_pc = target & 32'hFFFF_FFFC;
        @(posedge clock);
        cycle++;
        @(negedge clock);
    endtask

    // Reset DUT and memory model together, then check reset values
    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b0;
        mem_q.delete();
        inflight   = 0;
        last_ready = 0;
        repeat (2) begin
            @(posedge clock);
            cycle++;
            @(negedge clock);
        end
        check_value("rst_imem_req", 32'(imem_req), 32'd0);
        check_value("rst_imem_addr", imem_addr, 32'h0);
        check_value("rst_if_valid", 32'(if_valid), 32'd0);
        check_value("rst_if_instr", if_instr, 32'h0);
        check_value("rst_if_pc", if_pc, 32'h0);
        reset  = 1'b0;
        exp_pc = 32'h0;
    endtask

    initial begin
        int first;
        int c0;
        int n;
        logic found;

        @(negedge clock);

        // Always-grant, latency 1, no stall: first-valid latency and throughput
        do_reset();
        gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
        first = -1;
        c0 = consumed;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 32'h0);
            if (obs_valid && first < 0) first = k;
        end
        check_value("first_valid_latency", 32'(first), 32'(FIRST_VALID));
        check_value("throughput", 32'(consumed - c0), 32'(12 - FIRST_VALID));

        // ID stalled: requests stop at QUEUE_DEPTH, then drain in order
        do_reset();
        ready_pct = 0;
        grants = 0;
        repeat (10) step(1'b0, 32'h0);
        check_value("stall_grants", 32'(grants), 32'(QD));
        check_value("stall_req_low", 32'(obs_req), 32'd0);
        ready_pct = 100;
        c0 = consumed;
        for (int k = 0; k < 20 && (consumed - c0) < 4; k++) step(1'b0, 32'h0);
        check_value("drain_count", 32'(consumed - c0 >= 4), 32'd1);

        // Latency 3, two in flight, redirect to unaligned target
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 20 && inflight != 2; k++) step(1'b0, 32'h0);
        check_value("two_outstanding", 32'(inflight), 32'd2);
        step(1'b1, 32'h0000_0103);
        check_value("no_req_on_redirect", 32'(obs_req), 32'd0);
        c0 = consumed;
        for (int k = 0; k < 30 && consumed == c0; k++) step(1'b0, 32'h0);
        check_value("redirect_first_pc", last_pc, 32'h0000_0100);

        // Redirect coinciding with a response
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_q.size() > 0 && mem_q[0].ready <= cycle) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 32'h0);
        end
        check_value("rvalid_for_redirect", 32'(found), 32'd1);
        step(1'b1, 32'h0000_0200);
        check_value("discard_remaining", 32'(inflight), 32'(mem_q.size()));
        c0 = consumed;
        for (int k = 0; k < 30 && consumed == c0; k++) step(1'b0, 32'h0);
        check_value("redirect_rvalid_pc", last_pc, 32'h0000_0200);

        // Grant withheld: request held with a stable address
        do_reset();
        lat_min = 1; lat_max = 1;
        gnt_pct = 0;
        repeat (5) begin
            step(1'b0, 32'h0);
            check_value("gnt_stall_req", 32'(obs_req), 32'd1);
            check_value("gnt_stall_addr", obs_addr, 32'h0);
        end
        gnt_pct = 100;

        // Address wrap past the top of memory
        step(1'b1, 32'hFFFF_FFFC);
        c0 = consumed;
        for (int k = 0; k < 20 && (consumed - c0) < 2; k++) step(1'b0, 32'h0);
        n = pc_log.size();
        if (consumed - c0 >= 2) begin
            check_value("wrap_pc0", pc_log[c0], 32'hFFFF_FFFC);
            check_value("wrap_pc1", pc_log[c0 + 1], 32'h0000_0000);
        end else begin
            check_value("wrap_timeout", 32'(n - c0), 32'd2);
        end

        // Random traffic: grants, latency, stalls and redirects
        do_reset();
        c0 = consumed;
        for (int k = 0; k < 1500; k++) begin
            if (k % 250 == 0) begin
                gnt_pct   = int'($urandom_range(100, 30));
                ready_pct = int'($urandom_range(100, 30));
                lat_min   = 1;
                lat_max   = int'($urandom_range(4, 1));
            end
            if ($urandom_range(99) < 3) step(1'b1, $urandom);
            else                        step(1'b0, 32'h0);
        end
        check_value("random_progress", 32'(consumed > c0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_count, errors_count);
        $finish;
    end

endmodule
